// File: rtl/saber_pack_pkg.sv
// Shared constants and FSM state encoding for the Saber p-domain
// polynomial-vector packer/unpacker pair.
package saber_pack_pkg;

  localparam int unsigned COEFF_BITS_P    = 10;
  localparam int unsigned SLOT_BITS       = 16;
  localparam int unsigned WORD_BITS       = 64;
  localparam int unsigned GROUP_COEFFS    = 32;
  localparam int unsigned GROUP_IN_WORDS  = 8;
  localparam int unsigned GROUP_OUT_WORDS = 5;
  localparam int unsigned BUF_BITS        = GROUP_COEFFS * COEFF_BITS_P;
  localparam int unsigned CHUNK_BITS      = 4 * COEFF_BITS_P;

  typedef enum logic [4:0] {
    ST_IDLE = 5'd0,
    ST_R1   = 5'd1,
    ST_R2   = 5'd2,
    ST_R3   = 5'd3,
    ST_R4   = 5'd4,
    ST_R5   = 5'd5,
    ST_R6   = 5'd6,
    ST_R7   = 5'd7,
    ST_R8   = 5'd8,
    ST_R9   = 5'd9,
    ST_W1   = 5'd10,
    ST_W2   = 5'd11,
    ST_W3   = 5'd12,
    ST_W4   = 5'd13,
    ST_W5   = 5'd14,
    ST_DONE = 5'd15
  } pack_state_e;

endpackage

// File: rtl/slot4_to_40.sv
// Extracts four CB-bit coefficients from their 16-bit slots into one dense
// chunk (slot 0 in the low bits) and flags any set bit above a coefficient.
module slot4_to_40
  import saber_pack_pkg::*;
#(
  parameter int unsigned CB = COEFF_BITS_P
) (
  input  logic [WORD_BITS-1:0] slot_word,
  output logic [4*CB-1:0]      chunk,
  output logic                 range_bad
);

  always_comb begin
    chunk     = '0;
    range_bad = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      chunk[k*CB +: CB] = slot_word[k*SLOT_BITS +: CB];
      range_bad         = range_bad | (|slot_word[k*SLOT_BITS+CB +: SLOT_BITS-CB]);
    end
  end

endmodule

// File: rtl/polvecp2bs.sv
// Packs 768 slotted 10-bit coefficients (192 words) into a dense 120-word
// little-endian stream. Optional range check: POLVECP2BS_RANGE_CHECK_EN.
module polvecp2bs
  import saber_pack_pkg::*;
#(
  parameter int unsigned COEFF_BITS = 10,
  parameter int unsigned IN_WORDS   = 192,
  parameter int unsigned OUT_WORDS  = 120,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] read_address,
  input  logic [63:0]       read_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [63:0]       write_data,
  output logic              write_en,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_READ = ADDR_W'(IN_WORDS);

  pack_state_e           state_q, state_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [BUF_BITS-1:0]   buf_q, buf_d;
  logic                  inc_read, load, wr_strobe;
  logic [CHUNK_BITS-1:0] chunk;
  logic                  range_bad;

  // Output count is implied by IN_WORDS; the parameter stays for interface compatibility.
  logic [ADDR_W-1:0] out_words_unused;
  assign out_words_unused = ADDR_W'(OUT_WORDS);

  slot4_to_40 #(.CB(COEFF_BITS)) u_slot (
    .slot_word (read_data),
    .chunk     (chunk),
    .range_bad (range_bad)
  );

  always_comb begin
    state_d   = state_q;
    inc_read  = 1'b0;
    load      = 1'b0;
    wr_strobe = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_R1;
      ST_R1: begin
        inc_read = 1'b1;
        state_d  = ST_R2;
      end
      ST_R2, ST_R3, ST_R4, ST_R5, ST_R6, ST_R7, ST_R8: begin
        inc_read = 1'b1;
        load     = 1'b1;
        state_d  = pack_state_e'(state_q + 5'd1);
      end
      ST_R9: begin
        load    = 1'b1;
        state_d = ST_W1;
      end
      ST_W1, ST_W2, ST_W3, ST_W4: begin
        wr_strobe = 1'b1;
        state_d   = pack_state_e'(state_q + 5'd1);
      end
      ST_W5: begin
        wr_strobe = 1'b1;
        state_d   = (rd_addr_q == LAST_READ) ? ST_DONE : ST_R1;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    buf_d     = buf_q;
    if (inc_read) rd_addr_d = rd_addr_q + ADDR_ONE;
    if (wr_strobe) wr_addr_d = wr_addr_q + ADDR_ONE;
    // New chunks enter at the top, so the oldest coefficients drain from bit 0.
    if (load) begin
      buf_d = {chunk, buf_q[BUF_BITS-1:CHUNK_BITS]};
    end else if (wr_strobe) begin
      buf_d = {{WORD_BITS{1'b0}}, buf_q[BUF_BITS-1:WORD_BITS]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

`ifdef POLVECP2BS_RANGE_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (load & range_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic range_unused;
  assign range_unused = range_bad;
  assign err          = 1'b0;
`endif

  assign read_address  = rd_addr_q;
  assign write_address = wr_addr_q;
  assign write_data    = buf_q[WORD_BITS-1:0];
  assign write_en      = wr_strobe;
  assign done          = (state_q == ST_DONE);

endmodule
